// File: rtl/gemm_tile_engine_if.sv
// System-bus and scratchpad-port signals of gemm_tile_engine, bundled into one connection.
interface gemm_tile_engine_if #(
  parameter int TILE = 16
);
  logic                 system_bus_en;
  logic                 system_bus_rdwr;
  logic [31:0]          system_bus_addr;
  logic [31:0]          system_bus_wr_data;
  logic [31:0]          system_bus_rd_data;
  logic                 interface_en;
  logic                 interface_rdwr;
  logic [31:0]          interface_addr;
  logic [4:0]           interface_control;
  logic [3:0][31:0]     interface_wr_data;
  logic [8*TILE-1:0]    interface_rd_data;

  // Handshake: no ready signals anywhere. A bus access is a one-cycle en strobe, and
  // a memory request is a one-cycle interface_en strobe that the memory always accepts.
  // Read data returns on the following cycle.
  modport slave (
    input  system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    input  interface_rd_data,
    output system_bus_rd_data,
    output interface_en, interface_rdwr, interface_addr, interface_control, interface_wr_data
  );

  modport master (
    output system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    output interface_rd_data,
    input  system_bus_rd_data,
    input  interface_en, interface_rdwr, interface_addr, interface_control, interface_wr_data
  );
endinterface

// File: rtl/gemm_tile_engine.sv
// Tiled u8 x u8 -> u32 matrix-multiply engine: C (+)= A x B, with A and B rows read from a
// byte-row scratchpad and C rows written back in chunks of up to four words.
module gemm_tile_engine #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          TILE      = 16
) (
  input  logic              clk,
  input  logic              rst,
  gemm_tile_engine_if.slave bus,
  output logic [2:0]        dbg_state_o
);
  localparam int IW = $clog2(TILE);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_LOAD_A, S_MAC, S_WRITE_C} state_e;

  typedef struct packed {
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic [31:0] a_stride;
    logic [31:0] b_stride;
    logic        first;
    logic        last;
    logic [4:0]  msize;
    logic [4:0]  ksize;
    logic [4:0]  nsize;
  } job_t;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  row_q, row_d;
  job_t        stg_q, pend_q, job_q, pend_d;
  logic        pend_valid_q;
  logic [31:0] acc_q [TILE][TILE];
  logic [7:0]  b_q   [TILE][TILE];
  logic [7:0]  a_q   [TILE];

  logic [31:0] offset, wd;
  logic        hit, bus_wr, commit, start, done;
  logic [4:0]  idx, rem, brow;

  function automatic logic [4:0] clamp_size(input logic [4:0] v);
    return (v == 5'd0 || int'(v) > TILE) ? 5'(TILE) : v;
  endfunction

  function automatic logic [31:0] mul8(input logic [7:0] a, input logic [7:0] b);
    return 32'(a) * 32'(b);
  endfunction

  assign wd          = bus.system_bus_wr_data;
  assign offset      = bus.system_bus_addr - BASE_ADDR;
  assign hit         = bus.system_bus_en && (offset[31:5] == 27'd0);
  assign bus_wr      = hit && bus.system_bus_rdwr;
  assign commit      = bus_wr && (offset[4:0] == 5'd24) && !pend_valid_q;
  assign done        = (state_q == S_IDLE) && !pend_valid_q;
  assign brow        = job_q.ksize - cnt_q;
  assign dbg_state_o = state_q;

  always_comb begin
    bus.system_bus_rd_data = '0;
    if (hit && !bus.system_bus_rdwr) begin
      case (offset[4:0])
        5'd0:    bus.system_bus_rd_data = {31'b0, pend_valid_q};
        5'd24:   bus.system_bus_rd_data = {31'b0, done};
        default: bus.system_bus_rd_data = '0;
      endcase
    end
  end

  always_comb begin
    pend_d       = stg_q;
    pend_d.msize = clamp_size(wd[4:0]);
    pend_d.ksize = clamp_size(wd[9:5]);
    pend_d.nsize = clamp_size(wd[14:10]);
  end

  // Staged fields persist across commits; the active job is a private copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_q        <= '0;
      pend_q       <= '0;
      job_q        <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (bus_wr) begin
        case (offset[4:0])
          5'd0:    stg_q.a_addr   <= wd;
          5'd4:    stg_q.b_addr   <= wd;
          5'd8:    stg_q.c_addr   <= wd;
          5'd12:   stg_q.a_stride <= wd;
          5'd16:   stg_q.b_stride <= wd;
          5'd20:   {stg_q.first, stg_q.last} <= wd[1:0];
          default: ;
        endcase
      end
      if (commit) pend_q <= pend_d;
      if (start) begin
        job_q        <= pend_q;
        pend_valid_q <= 1'b0;
      end else if (commit) begin
        pend_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    row_d                 = row_q;
    start                 = 1'b0;
    idx                   = '0;
    rem                   = '0;
    bus.interface_en      = 1'b0;
    bus.interface_rdwr    = 1'b0;
    bus.interface_addr    = '0;
    bus.interface_control = '0;
    bus.interface_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          start   = 1'b1;
          state_d = S_LOAD_B;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_LOAD_B: begin
        // B is fetched from its last row downward; the extra cycle captures the final row.
        if (cnt_q < job_q.ksize) begin
          bus.interface_en      = 1'b1;
          bus.interface_addr    = job_q.b_addr - 32'(cnt_q) * job_q.b_stride;
          bus.interface_control = job_q.nsize;
          cnt_d                 = cnt_q + 5'd1;
        end else begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        if (cnt_q == 5'd0) begin
          bus.interface_en      = 1'b1;
          bus.interface_addr    = job_q.a_addr + 32'(row_q) * job_q.a_stride;
          bus.interface_control = job_q.ksize;
          cnt_d                 = 5'd1;
        end else begin
          state_d = S_MAC;
          cnt_d   = '0;
        end
      end
      S_MAC: begin
        if (cnt_q == job_q.ksize - 5'd1) begin
          cnt_d = '0;
          if (row_q == job_q.msize - 5'd1) begin
            row_d   = '0;
            state_d = job_q.last ? S_WRITE_C : S_IDLE;
          end else begin
            row_d   = row_q + 5'd1;
            state_d = S_LOAD_A;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_WRITE_C: begin
        rem                   = job_q.nsize - cnt_q;
        bus.interface_en      = 1'b1;
        bus.interface_rdwr    = 1'b1;
        bus.interface_addr    = job_q.c_addr + 32'(row_q) * job_q.b_stride + 32'(cnt_q);
        bus.interface_control = (rem > 5'd4) ? 5'd4 : rem;
        for (int w = 0; w < 4; w++) begin
          idx = cnt_q + 5'(w);
          if (idx < job_q.nsize) bus.interface_wr_data[w] = acc_q[row_q[IW-1:0]][idx[IW-1:0]];
        end
        if (cnt_q + 5'd4 >= job_q.nsize) begin
          cnt_d = '0;
          if (row_q == job_q.msize - 5'd1) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 5'd4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < TILE; r++) begin
        a_q[r] <= '0;
        for (int c = 0; c < TILE; c++) begin
          acc_q[r][c] <= '0;
          b_q[r][c]   <= '0;
        end
      end
    end else begin
      if (start && pend_q.first) begin
        for (int r = 0; r < TILE; r++)
          for (int c = 0; c < TILE; c++) acc_q[r][c] <= '0;
      end
      if (state_q == S_LOAD_B && cnt_q != 5'd0) begin
        for (int c = 0; c < TILE; c++)
          b_q[brow[IW-1:0]][c] <= (5'(c) < job_q.nsize) ? bus.interface_rd_data[8*c +: 8] : 8'd0;
      end
      if (state_q == S_LOAD_A && cnt_q == 5'd1) begin
        for (int c = 0; c < TILE; c++) a_q[c] <= bus.interface_rd_data[8*c +: 8];
      end
      if (state_q == S_MAC) begin
        for (int c = 0; c < TILE; c++)
          acc_q[row_q[IW-1:0]][c] <= acc_q[row_q[IW-1:0]][c]
                                     + mul8(a_q[cnt_q[IW-1:0]], b_q[cnt_q[IW-1:0]][c]);
      end
    end
  end
endmodule

// File: tb/tb_gemm_tile_engine.sv
// Directed bench for gemm_tile_engine: scratchpad model, C-write scoreboard, register and
// latency checks.
module tb_gemm_tile_engine;
  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int          RW   = 168;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  gemm_tile_engine_if #(.TILE(16)) bus_if ();

  gemm_tile_engine #(.BASE_ADDR(BASE), .TILE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scratchpad model ----------------
  logic [7:0] mem [4096];

  always @(posedge clk) begin
    if (bus_if.interface_en && !bus_if.interface_rdwr)
      for (int b = 0; b < 16; b++)
        bus_if.interface_rd_data[8*b +: 8] <= mem[int'((bus_if.interface_addr + 32'(b)) & 32'hFFF)];
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_rec;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic [31:0] addr, input logic [4:0] ctrl,
                                           input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    return {addr, 3'b000, ctrl, w3, w2, w1, w0};
  endfunction

  always @(negedge clk) begin
    if (rst && bus_if.interface_en && bus_if.interface_rdwr) begin
      obs_rec = mk_rec(bus_if.interface_addr, bus_if.interface_control,
                       bus_if.interface_wr_data[0], bus_if.interface_wr_data[1],
                       bus_if.interface_wr_data[2], bus_if.interface_wr_data[3]);
      if (exp_q.size() == 0) check("wr_unexpected", obs_rec, '0);
      else                   check("wr_c", obs_rec, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (enter and return at a negedge) ----------------
  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    bus_if.system_bus_en      = 1'b1;
    bus_if.system_bus_rdwr    = 1'b1;
    bus_if.system_bus_addr    = BASE + off;
    bus_if.system_bus_wr_data = data;
    @(negedge clk);
    bus_if.system_bus_en      = 1'b0;
    bus_if.system_bus_rdwr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
    bus_if.system_bus_en   = 1'b1;
    bus_if.system_bus_rdwr = 1'b0;
    bus_if.system_bus_addr = BASE + off;
    #1;
    data = bus_if.system_bus_rd_data;
    @(negedge clk);
    bus_if.system_bus_en   = 1'b0;
  endtask

  task automatic program_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] as, input logic [31:0] bs, input logic [1:0] ctl);
    bus_write(32'd0,  a);
    bus_write(32'd4,  b);
    bus_write(32'd8,  c);
    bus_write(32'd12, as);
    bus_write(32'd16, bs);
    bus_write(32'd20, {30'b0, ctl});
  endtask

  function automatic logic [31:0] dim(input int n, input int k, input int m);
    return {17'b0, 5'(n), 5'(k), 5'(m)};
  endfunction

  task automatic wait_done(input string tag, output int lat);
    logic [31:0] d;
    lat = 0;
    d   = '0;
    for (int i = 0; i < 2000; i++) begin
      bus_read(32'd24, d);
      if (d[0]) break;
      lat++;
    end
    check(tag, d, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  int          lat;

  initial begin
    bus_if.system_bus_en      = 1'b0;
    bus_if.system_bus_rdwr    = 1'b0;
    bus_if.system_bus_addr    = '0;
    bus_if.system_bus_wr_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_outputs", {bus_if.interface_en, bus_if.interface_rdwr, bus_if.interface_addr,
                              bus_if.interface_control, bus_if.interface_wr_data}, '0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(32'd24, d); check("rst_done", d, 1);
    bus_read(32'd0,  d); check("rst_full", d, 0);
    bus_read(32'd28, d); check("unmapped_rd", d, 0);
    bus_read(32'd4,  d); check("wo_reg_rd", d, 0);

    // single tile: A 2x3, B 3x2
    for (int i = 0; i < 6; i++) begin
      mem[32'h100 + i] = 8'(i + 1);
      mem[32'h200 + i] = 8'(i + 7);
    end
    program_job(32'h100, 32'h204, 32'h1000, 32'd3, 32'd2, 2'b11);
    exp_q.push_back(mk_rec(32'h1000, 5'd2, 32'd58,  32'd64,  32'd0, 32'd0));
    exp_q.push_back(mk_rec(32'h1002, 5'd2, 32'd139, 32'd154, 32'd0, 32'd0));
    bus_write(32'd24, dim(2, 3, 2));
    wait_done("single_done", lat);
    check("single_latency", lat, 17);
    check("single_sb_empty", exp_q.size(), 0);

    // K split: A rows all 1 / all 2 (K=20), B rows [1,2] -> C = [[20,40],[40,80]]
    for (int k = 0; k < 20; k++) begin
      mem[32'h300 + k]     = 8'd1;
      mem[32'h314 + k]     = 8'd2;
      mem[32'h400 + 2*k]   = 8'd1;
      mem[32'h401 + 2*k]   = 8'd2;
    end
    exp_q.push_back(mk_rec(32'h1100, 5'd2, 32'd20, 32'd40, 32'd0, 32'd0));
    exp_q.push_back(mk_rec(32'h1102, 5'd2, 32'd40, 32'd80, 32'd0, 32'd0));
    program_job(32'h300, 32'h41E, 32'h1100, 32'd20, 32'd2, 2'b10);
    bus_write(32'd24, dim(2, 16, 2));
    program_job(32'h310, 32'h426, 32'h1100, 32'd20, 32'd2, 2'b01);
    bus_write(32'd24, dim(2, 4, 2));
    wait_done("ksplit_done", lat);
    check("ksplit_sb_empty", exp_q.size(), 0);

    // queue: two jobs accepted, third DIM dropped while FULL
    program_job(32'h100, 32'h204, 32'h1200, 32'd3, 32'd2, 2'b11);
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(mk_rec(32'h1200, 5'd2, 32'd58,  32'd64,  32'd0, 32'd0));
      exp_q.push_back(mk_rec(32'h1202, 5'd2, 32'd139, 32'd154, 32'd0, 32'd0));
    end
    bus_write(32'd24, dim(2, 3, 2));
    bus_write(32'd8, 32'h1200);
    bus_write(32'd24, dim(2, 3, 2));
    bus_read(32'd0,  d); check("queue_full", d, 1);
    bus_read(32'd24, d); check("busy_done", d, 0);
    bus_write(32'd8, 32'h1300);
    bus_write(32'd24, dim(2, 3, 2));
    bus_read(32'd0,  d); check("queue_full_held", d, 1);
    wait_done("queue_done", lat);
    bus_read(32'd0,  d); check("queue_full_clear", d, 0);
    check("queue_sb_empty", exp_q.size(), 0);

    // nsize = 5: chunks of 4 then 1, junk past the B row must not matter
    mem[32'h500] = 8'd2;
    for (int c = 0; c < 16; c++) mem[32'h510 + c] = (c < 5) ? 8'(c + 1) : 8'd9;
    program_job(32'h500, 32'h510, 32'h1400, 32'd1, 32'd5, 2'b11);
    exp_q.push_back(mk_rec(32'h1400, 5'd4, 32'd2,  32'd4, 32'd6, 32'd8));
    exp_q.push_back(mk_rec(32'h1404, 5'd1, 32'd10, 32'd0, 32'd0, 32'd0));
    bus_write(32'd24, dim(5, 1, 1));
    wait_done("n5_done", lat);
    check("n5_sb_empty", exp_q.size(), 0);

    // extremes: all 255, sizes 16 via n=16, k=0 (clamped), m=31 (clamped)
    for (int i = 0; i < 512; i++) mem[32'h600 + i] = 8'd255;
    program_job(32'h600, 32'h7F0, 32'h2000, 32'd16, 32'd16, 2'b11);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j += 4)
        exp_q.push_back(mk_rec(32'h2000 + 32'(16*i + j), 5'd4,
                               32'd1040400, 32'd1040400, 32'd1040400, 32'd1040400));
    bus_write(32'd24, dim(16, 0, 31));
    wait_done("ext_done", lat);
    check("ext_latency", lat, 370);
    check("ext_sb_empty", exp_q.size(), 0);

    // reset mid-job (accumulators hold 1040400 and first=0), then verify they were cleared
    program_job(32'h100, 32'h204, 32'h3000, 32'd3, 32'd2, 2'b01);
    bus_write(32'd24, dim(2, 3, 2));
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_mem_outputs", {bus_if.interface_en, bus_if.interface_rdwr, bus_if.interface_addr,
                                bus_if.interface_control, bus_if.interface_wr_data}, '0);
    check("abort_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(32'd24, d); check("abort_done", d, 1);
    bus_read(32'd0,  d); check("abort_full", d, 0);
    program_job(32'h100, 32'h204, 32'h3100, 32'd3, 32'd2, 2'b01);
    exp_q.push_back(mk_rec(32'h3100, 5'd2, 32'd58,  32'd64,  32'd0, 32'd0));
    exp_q.push_back(mk_rec(32'h3102, 5'd2, 32'd139, 32'd154, 32'd0, 32'd0));
    bus_write(32'd24, dim(2, 3, 2));
    wait_done("post_rst_done", lat);
    check("post_rst_sb_empty", exp_q.size(), 0);

    // final report
    repeat (2) @(negedge clk);
    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
